mul_div_unit: RTL and testbench

//  Iterative multiply/divide unit of the MIPS EX stage. Executes MULT/MULTU/DIV/DIVU

---
 rtl/mul_div_unit.sv | 247 ++++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers (shift-add / restoring divide).
// Optional divider datapath is built only when MULDIV_DIV_EN is defined.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivByZero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_e;

  state_e             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               is_div_q,  is_div_d;
  logic               neg_q,     neg_d;
  logic [WIDTH-1:0]   opnd_q,    opnd_d;
  logic [WIDTH-1:0]   acc_hi_q,  acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q,  acc_lo_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic [WIDTH-1:0]   hi_q,      hi_d;
  logic [WIDTH-1:0]   lo_q,      lo_d;
  logic               dbz_q,     dbz_d;
`ifdef MULDIV_DIV_EN
  logic               rem_neg_q, rem_neg_d;
  logic               zero_div_q, zero_div_d;
`endif

  // Operand magnitudes; only MULT (00) and DIV (10) are signed
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  always_comb begin
    op_signed = ~Op[0];
    a_neg     = op_signed & OperandA[WIDTH-1];
    b_neg     = op_signed & OperandB[WIDTH-1];
    abs_a     = a_neg ? (WIDTH'(0) - OperandA) : OperandA;
    abs_b     = b_neg ? (WIDTH'(0) - OperandB) : OperandB;
  end

  // One shift-add multiply step: {acc_hi, acc_lo} accumulates the product, acc_lo shifts out the multiplier
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nxt;
  logic [WIDTH-1:0] mul_lo_nxt;

  always_comb begin
    mul_addend = acc_lo_q[0] ? opnd_q : '0;
    mul_sum    = {1'b0, acc_hi_q} + {1'b0, mul_addend};
    mul_hi_nxt = mul_sum[WIDTH:1];
    mul_lo_nxt = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  // One restoring divide step: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] div_hi_nxt;
  logic [WIDTH-1:0] div_lo_nxt;

  always_comb begin
    div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    if (div_diff[WIDTH]) begin
      div_hi_nxt = div_sh[WIDTH-1:0];
      div_lo_nxt = {acc_lo_q[WIDTH-2:0], 1'b0};
    end else begin
      div_hi_nxt = div_diff[WIDTH-1:0];
      div_lo_nxt = {acc_lo_q[WIDTH-2:0], 1'b1};
    end
  end
`endif

  // Sign correction of the finished result
  logic [PW-1:0]    prod_raw;
  logic [PW-1:0]    prod_fix;

  always_comb begin
    prod_raw = {acc_hi_q, acc_lo_q};
    prod_fix = neg_q ? (PW'(0) - prod_raw) : prod_raw;
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // A zero divisor leaves the dividend magnitude in the remainder, so the normal
  // remainder sign fix already returns the original dividend on Hi
  always_comb begin
    quo_fix = zero_div_q ? '1 : (neg_q ? (WIDTH'(0) - acc_lo_q) : acc_lo_q);
    rem_fix = rem_neg_q ? (WIDTH'(0) - acc_hi_q) : acc_hi_q;
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
`ifdef MULDIV_DIV_EN
    rem_neg_d  = rem_neg_q;
    zero_div_d = zero_div_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Busy is still high during the Done cycle, blocking a new Start there
        if (done_q) begin
          busy_d = 1'b0;
        end
        if (Start && !busy_q) begin
          busy_d   = 1'b1;
          is_div_d = Op[1];
          neg_d    = a_neg ^ b_neg;
          cnt_d    = '0;
          acc_hi_d = '0;
          state_d  = S_RUN;
          if (Op[1]) begin
            acc_lo_d = abs_a;
            opnd_d   = abs_b;
`ifdef MULDIV_DIV_EN
            rem_neg_d  = a_neg;
            zero_div_d = (OperandB == '0);
`else
            state_d    = S_FINISH;
`endif
          end else begin
            acc_lo_d = abs_b;
            opnd_d   = abs_a;
          end
        end
      end

      S_RUN: begin
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          acc_hi_d = div_hi_nxt;
          acc_lo_d = div_lo_nxt;
        end else begin
          acc_hi_d = mul_hi_nxt;
          acc_lo_d = mul_lo_nxt;
        end
`else
        acc_hi_d = mul_hi_nxt;
        acc_lo_d = mul_lo_nxt;
`endif
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        done_d  = 1'b1;
        dbz_d   = 1'b0;
        state_d = S_IDLE;
        if (is_div_q) begin
`ifdef MULDIV_DIV_EN
          hi_d  = rem_fix;
          lo_d  = quo_fix;
          dbz_d = zero_div_q;
`endif
        end else begin
          hi_d = prod_fix[PW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_neg_q  <= 1'b0;
      zero_div_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
`ifdef MULDIV_DIV_EN
      rem_neg_q  <= rem_neg_d;
      zero_div_q <= zero_div_d;
`endif
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed + random bench for mul_div_unit; expected results are queued at Start and checked at Done.
module tb_mul_div_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        DivByZero;

  mul_div_unit #(.WIDTH(32)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .OperandA (OperandA),
    .OperandB (OperandB),
    .Busy     (Busy),
    .Done     (Done),
    .Hi       (Hi),
    .Lo       (Lo),
    .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    logic [7:0]  cycles;
  } exp_t;

  exp_t        sb_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  logic        model_dbz = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model built on the simulator's own 64-bit and signed arithmetic
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [63:0] p;
    int          sa;
    int          sb;
    sa       = $signed(a);
    sb       = $signed(b);
    r.hi     = model_hi;
    r.lo     = model_lo;
    r.dbz    = 1'b0;
    r.cycles = 8'd34;
    case (op)
      2'b00: begin
        p    = 64'(longint'(sa) * longint'(sb));
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      2'b01: begin
        p    = {32'd0, a} * {32'd0, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) begin
          r.lo  = 32'hFFFF_FFFF;
          r.hi  = a;
          r.dbz = 1'b1;
        end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.lo = 32'h8000_0000;
          r.hi = 32'd0;
        end else if (op == 2'b10) begin
          r.lo = 32'(sa / sb);
          r.hi = 32'(sa % sb);
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
`else
        r.cycles = 8'd2;
`endif
      end
    endcase
    return r;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit repulse);
    exp_t        e;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    logic        prev_dbz;
    bit          hold_ok = 1'b1;
    bit          busy_ok = 1'b1;
    bit          seen    = 1'b0;
    int          cyc;
    int          extra   = 0;

    for (int i = 0; i < 100 && Busy !== 1'b0; i++) begin
      @(posedge Clk); #1;
    end
    chk("idle_before_start", {63'd0, Busy}, 64'd0);
    chk("no_stale_done", {63'd0, Done}, 64'd0);

    prev_hi  = model_hi;
    prev_lo  = model_lo;
    prev_dbz = model_dbz;
    e = model(op, a, b);
    sb_q.push_back(e);
    model_hi  = e.hi;
    model_lo  = e.lo;
    model_dbz = e.dbz;

    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(posedge Clk); #1;
    Start = 1'b0; OperandA = $urandom; OperandB = $urandom;
    cyc = 1;
    for (int i = 0; i < 100; i++) begin
      if (Busy !== 1'b1) busy_ok = 1'b0;
      if (Done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (Hi !== prev_hi || Lo !== prev_lo || DivByZero !== prev_dbz) hold_ok = 1'b0;
      if (repulse && cyc == 5) begin
        Start = 1'b1; Op = op ^ 2'b01;
      end else begin
        Start = 1'b0;
      end
      @(posedge Clk); #1;
      cyc++;
    end
    Start = 1'b0;

    if (!seen) begin
      chk("done_timeout", 64'd0, 64'd1);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      chk("hi", {32'd0, Hi}, {32'd0, e.hi});
      chk("lo", {32'd0, Lo}, {32'd0, e.lo});
      chk("div_by_zero", {63'd0, DivByZero}, {63'd0, e.dbz});
      chk("latency", 64'(cyc), {56'd0, e.cycles});
      chk("hold_until_done", {63'd0, hold_ok}, 64'd1);
      chk("busy_while_active", {63'd0, busy_ok}, 64'd1);
    end

    if (repulse) begin
      for (int i = 0; i < 45; i++) begin
        @(posedge Clk); #1;
        if (Done === 1'b1) extra++;
      end
      chk("single_done", 64'(extra), 64'd0);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          extra;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    Reset = 1'b1; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_busy", {63'd0, Busy}, 64'd0);
    chk("reset_done", {63'd0, Done}, 64'd0);
    chk("reset_hi", {32'd0, Hi}, 64'd0);
    chk("reset_lo", {32'd0, Lo}, 64'd0);
    chk("reset_dbz", {63'd0, DivByZero}, 64'd0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    run_op(2'b11, 32'h0000_1234, 32'd0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0);

    // Back-to-back: each run_op starts in the cycle right after the previous Done
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    run_op(2'b10, 32'd1000, 32'hFFFF_FFFD, 1'b0);
    for (int k = 0; k < 6; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (k == 3) ? 32'($urandom_range(1, 15)) : $urandom;
      run_op(rop, ra, rb, 1'b0);
    end

    // Reset in the middle of a multiply aborts it
    for (int i = 0; i < 100 && Busy !== 1'b0; i++) begin
      @(posedge Clk); #1;
    end
    Start = 1'b1; Op = 2'b01; OperandA = 32'hDEAD_BEEF; OperandB = 32'h0000_1111;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    model_hi = '0; model_lo = '0; model_dbz = 1'b0;
    chk("abort_busy", {63'd0, Busy}, 64'd0);
    chk("abort_hi", {32'd0, Hi}, 64'd0);
    chk("abort_lo", {32'd0, Lo}, 64'd0);
    extra = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge Clk); #1;
      if (Done === 1'b1) extra++;
    end
    chk("abort_no_done", 64'(extra), 64'd0);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'd16, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
